// File: rtl/serial_adder_pkg.sv
// Shared types and sizing for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CARRY  = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam int WIDTH_DEFAULT = 8;
  localparam int WIDTH_MAX     = 16;
  localparam int CNT_W         = $clog2(WIDTH_MAX);

endpackage

// File: rtl/serial_adder_tx_full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR; purely combinational.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;
  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;
  assign cout  = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_tx.sv
// Bit-serial A+B streamed LSB-first then carry; first beat 1 cycle after load accept.
// tx_ready low or ena low holds all state; SERIAL_ADDER_PARITY_EN appends an even-parity beat.
module serial_adder_tx
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_bit,
  output logic             tx_last,
  output logic             busy
);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic              c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`ifdef SERIAL_ADDER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic fa_s;
  logic fa_cout;
  logic tx_hs;

  full_adder_bit u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign tx_hs = ena & tx_ready;

  always_comb begin
    state_d    = state_q;
    sa_d       = sa_q;
    sb_d       = sb_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
`ifdef SERIAL_ADDER_PARITY_EN
    par_d      = par_q;
`endif
    load_ready = 1'b0;
    tx_valid   = 1'b0;
    tx_bit     = 1'b0;
    tx_last    = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        // rst_n gate keeps load_ready low while reset is held
        load_ready = ena & rst_n;
        if (load_valid && ena && rst_n) begin
          sa_d    = op_a;
          sb_d    = op_b;
          c_d     = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_PARITY_EN
          par_d   = 1'b0;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        tx_valid = ena;
        tx_bit   = ena & fa_s;
        if (tx_hs) begin
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          c_d   = fa_cout;
          cnt_d = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADDER_PARITY_EN
          par_d = par_q ^ fa_s;
`endif
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = CARRY;
        end
      end
      CARRY: begin
        busy     = 1'b1;
        tx_valid = ena;
        tx_bit   = ena & c_q;
`ifdef SERIAL_ADDER_PARITY_EN
        if (tx_hs) begin
          par_d   = par_q ^ c_q;
          state_d = PARITY;
        end
`else
        tx_last  = ena;
        if (tx_hs) state_d = IDLE;
`endif
      end
`ifdef SERIAL_ADDER_PARITY_EN
      PARITY: begin
        busy     = 1'b1;
        tx_valid = ena;
        tx_bit   = ena & par_q;
        tx_last  = ena;
        if (tx_hs) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_adder_tx.sv
// Directed bench for serial_adder_tx: hand-computed sums, backpressure, ena gap, busy loads, mid-frame reset.
module tb_serial_adder_tx;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_PARITY_EN
  localparam int FRAME = WIDTH + 2;
`else
  localparam int FRAME = WIDTH + 1;
`endif

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_bit;
  logic             tx_last;
  logic             busy;

  int tests;
  int fails;

  serial_adder_tx #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_bit     (tx_bit),
    .tx_last    (tx_last),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic do_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    op_a       = a;
    op_b       = b;
    load_valid = 1'b1;
    #1;
    check("load_rdy", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    #1;
    check("first_vld", tx_valid, 1);
    check("busy_set", busy, 1);
  endtask

  task automatic run_frame(input string name, input logic [8:0] exp, input bit rnd,
                           input int drop_at, input int pulse_at);
    logic [9:0] val;
    int         beats;
    bit         have_prev, dropped, pulsed, pulse_now;
    logic       prev_bit, prev_last;
    val       = '0;
    beats     = 0;
    have_prev = 0;
    dropped   = 0;
    pulsed    = 0;
    prev_bit  = 0;
    prev_last = 0;
    for (int cyc = 0; cyc < 300 && beats < FRAME; cyc++) begin
      @(negedge clk);
      if (beats == drop_at && !dropped) begin
        dropped   = 1;
        have_prev = 0;
        ena       = 1'b0;
        tx_ready  = 1'b1;
        for (int g = 0; g < 5; g++) begin
          #1;
          check("gap_vld", tx_valid, 0);
          check("gap_bit", tx_bit, 0);
          check("gap_ldrdy", load_ready, 0);
          @(negedge clk);
        end
        ena = 1'b1;
      end
      tx_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pulse_now = (beats == pulse_at && !pulsed);
      if (pulse_now) begin
        pulsed     = 1;
        load_valid = 1'b1;
        op_a       = 8'hFF;
        op_b       = 8'hFF;
      end else begin
        load_valid = 1'b0;
      end
      #1;
      if (pulse_now) check("busy_ldrdy", load_ready, 0);
      if (have_prev) begin
        check("stall_vld", tx_valid, 1);
        check("stall_bit", tx_bit, prev_bit);
        check("stall_last", tx_last, prev_last);
      end
      if (tx_valid && tx_ready) begin
        val[beats] = tx_bit;
        check("tx_last", tx_last, (beats == FRAME - 1) ? 1 : 0);
        beats++;
        have_prev = 0;
      end else if (tx_valid) begin
        have_prev = 1;
        prev_bit  = tx_bit;
        prev_last = tx_last;
      end else begin
        have_prev = 0;
      end
    end
    load_valid = 1'b0;
    check({name, "_beats"}, beats, FRAME);
    check({name, "_sum"}, {23'd0, val[8:0]}, {23'd0, exp});
`ifdef SERIAL_ADDER_PARITY_EN
    check({name, "_par"}, val[9], ^exp);
`endif
    @(negedge clk);
    tx_ready = 1'b0;
    #1;
    check({name, "_ldrdy_after"}, load_ready, 1);
    check({name, "_busy_after"}, busy, 0);
    check({name, "_vld_after"}, tx_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests      = 0;
    fails      = 0;
    rst_n      = 1'b0;
    ena        = 1'b1;
    load_valid = 1'b0;
    op_a       = '0;
    op_b       = '0;
    tx_ready   = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ldrdy", load_ready, 0);
    check("rst_vld", tx_valid, 0);
    check("rst_bit", tx_bit, 0);
    check("rst_last", tx_last, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ldrdy", load_ready, 1);
    ena = 1'b0;
    #1;
    check("ena_low_ldrdy", load_ready, 0);
    ena = 1'b1;

    do_load(8'h03, 8'h05);
    run_frame("basic", 9'h008, 0, -1, -1);

    do_load(8'hFF, 8'h01);
    run_frame("ripple", 9'h100, 0, -1, -1);

    do_load(8'hFF, 8'hFF);
    run_frame("max", 9'h1FE, 0, -1, -1);

    do_load(8'hA5, 8'h5A);
    run_frame("bp", 9'h0FF, 1, -1, -1);

    do_load(8'h3C, 8'h4B);
    run_frame("ena_busy", 9'h087, 0, 3, 2);

    do_load(8'h55, 8'h0F);
    tx_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_vld", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ldrdy", load_ready, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    tx_ready = 1'b0;
    #1;
    check("rel_rst_ldrdy", load_ready, 1);
    check("rel_rst_vld", tx_valid, 0);

    do_load(8'h10, 8'h20);
    run_frame("after_rst", 9'h030, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
